// File: rtl/matmul_dot_sched_pkg.sv
// matmul_pkg: shared state, tag and sizing helpers for the matrix-multiply sequencer.
package matmul_pkg;
    localparam int MAX_ADDR_W = 12;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    typedef struct packed {
        logic                  first;
        logic                  last;
        logic [MAX_ADDR_W-1:0] idx;
    } tag_t;
    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++)
            if ((1 << r) >= v) return r;
        return 31;
    endfunction
endpackage

// File: rtl/matmul_dot_sched_if.sv
// matmul_dot_sched_if: control, A/B memory, multiplier and C-write signals of the sequencer.
interface matmul_dot_sched_if #(
    parameter int A_W    = 14,
    parameter int B_W    = 14,
    parameter int P_W    = 28,
    parameter int ACC_W  = 31,
    parameter int ADDR_W = 6
);
    logic              start, busy, done;
    logic              a_ce, b_ce, mul_ce, c_we;
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
    logic [A_W-1:0]    a_q, mul_din0;
    logic [B_W-1:0]    b_q, mul_din1;
    logic [P_W-1:0]    mul_dout;
    logic [ACC_W-1:0]  c_d;
    modport master (
        input  start, a_q, b_q, mul_dout,
        output busy, done, a_ce, a_addr, b_ce, b_addr, mul_ce, mul_din0, mul_din1, c_we, c_addr, c_d
    );
    modport slave (
        output start, a_q, b_q, mul_dout,
        input  busy, done, a_ce, a_addr, b_ce, b_addr, mul_ce, mul_din0, mul_din1, c_we, c_addr, c_d
    );
endinterface

// File: rtl/matmul_dot_sched_idx_counter.sv
// matmul_idx_counter: nested i/j/k loop counters (k innermost) that wrap to zero after the final issue.
module matmul_idx_counter #(
    parameter int DIM = 8,
    parameter int IW  = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en_i,
    output logic [IW-1:0] i_o,
    output logic [IW-1:0] j_o,
    output logic [IW-1:0] k_o,
    output logic          first_o,
    output logic          last_o,
    output logic          final_o
);
    localparam logic [IW-1:0] MAX = IW'(DIM - 1);
    logic [IW-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
    logic j_wrap;
    assign last_o  = k_q == MAX;
    assign first_o = k_q == '0;
    assign j_wrap  = last_o && j_q == MAX;
    assign final_o = j_wrap && i_q == MAX;
    always_comb begin
        k_d = en_i ? (last_o ? '0 : k_q + 1'b1) : k_q;
        j_d = en_i && last_o ? (j_wrap ? '0 : j_q + 1'b1) : j_q;
        i_d = en_i && j_wrap ? (final_o ? '0 : i_q + 1'b1) : i_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end
    assign i_o = i_q;
    assign j_o = j_q;
    assign k_o = k_q;
endmodule

// File: rtl/matmul_dot_sched.sv
// matmul_dot_sched: sequences C = A x B through 1-cycle A/B memories and the shared 2-stage multiplier,
// one multiply per clock, accumulating each dot product and writing C row-major.
module matmul_dot_sched
    import matmul_pkg::*;
#(
    parameter int DIM    = 8,
    parameter int A_W    = 14,
    parameter int B_W    = 14,
    parameter int P_W    = 28,
    parameter int ACC_W  = 31,
    parameter int ADDR_W = 6
) (
    input logic                clk,
    input logic                reset_n,
    matmul_dot_sched_if.master bus
);
    localparam int IW = (DIM > 1) ? clog2(DIM) : 1;
    if (P_W != A_W + B_W) begin : g_pw_bad
        $error("P_W must equal A_W + B_W");
    end
    if (ACC_W < P_W + clog2(DIM)) begin : g_acc_bad
        $error("ACC_W too narrow to hold a DIM-term dot product");
    end
    if (ADDR_W != ((DIM > 1) ? clog2(DIM * DIM) : 1)) begin : g_addr_bad
        $error("ADDR_W must equal clog2(DIM*DIM), minimum 1");
    end
    state_e           state_q, state_d;
    logic             drain_q, drain_d, issue, first, last, fin, v1_q, v2_q;
    logic [IW-1:0]    i, j, k;
    tag_t             tag0, tag1_q, tag2_q;
    logic [ACC_W-1:0] acc_q, sum;
    matmul_idx_counter #(.DIM(DIM), .IW(IW)) u_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (issue),
        .i_o     (i),
        .j_o     (j),
        .k_o     (k),
        .first_o (first),
        .last_o  (last),
        .final_o (fin)
    );
    assign issue = state_q == RUN;
    assign tag0  = '{first, last, MAX_ADDR_W'(i * DIM + j)};
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = fin ? DRAIN : RUN;
            DRAIN: begin
                drain_d = ~drain_q;
                state_d = drain_q ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end
    // tags travel alongside the memory and multiplier latencies so S2 knows where each product belongs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            v1_q    <= issue;
            v2_q    <= v1_q;
            tag1_q  <= tag0;
            tag2_q  <= tag1_q;
            if (v2_q) acc_q <= sum;
        end
    end
    assign sum          = (tag2_q.first ? '0 : acc_q) + ACC_W'(bus.mul_dout);
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == DONE;
    assign bus.a_ce     = issue;
    assign bus.b_ce     = issue;
    assign bus.a_addr   = ADDR_W'(i * DIM + k);
    assign bus.b_addr   = ADDR_W'(k * DIM + j);
    assign bus.mul_ce   = v1_q;
    assign bus.mul_din0 = bus.a_q;
    assign bus.mul_din1 = bus.b_q;
    assign bus.c_we     = v2_q && tag2_q.last;
    assign bus.c_addr   = bus.c_we ? tag2_q.idx[ADDR_W-1:0] : '0;
    assign bus.c_d      = bus.c_we ? sum : '0;
endmodule

// File: tb/tb_matmul_dot_sched.sv
// tb_matmul_dot_sched: four sequencers (DIM 1,2,4,8) with memory and multiplier models;
// expected C writes are queued from a plain triple-loop product and popped by a monitor.
module tb_matmul_dot_sched;
    typedef struct {
        longint cyc;
        longint addr;
        longint data;
    } exp_t;
    logic        clk = 1'b0;
    logic        rn[4] = '{default: 1'b0};
    logic        start_r[4] = '{default: 1'b0};
    logic [13:0] a_mem[4][64];
    logic [13:0] b_mem[4][64];
    logic        we_w[4], done_w[4], busy_w[4], mce_w[4], quiet_w[4];
    logic [11:0] caddr_w[4];
    logic [30:0] cd_w[4];
    exp_t        exp_q[4][$];
    time         t1[4];
    int          mce_cnt[4] = '{default: 0};
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D  = 1 << g;
        localparam int AW = (g == 0) ? 1 : 2 * g;
        matmul_dot_sched_if #(.A_W(14), .B_W(14), .P_W(28), .ACC_W(31), .ADDR_W(AW)) bus ();
        matmul_dot_sched #(.DIM(D), .A_W(14), .B_W(14), .P_W(28), .ACC_W(31), .ADDR_W(AW)) dut (
            .clk     (clk),
            .reset_n (rn[g]),
            .bus     (bus)
        );
        assign bus.start = start_r[g];
        always @(posedge clk) begin
            if (bus.a_ce) bus.a_q <= a_mem[g][bus.a_addr];
            if (bus.b_ce) bus.b_q <= b_mem[g][bus.b_addr];
            if (bus.mul_ce) bus.mul_dout <= bus.mul_din0 * bus.mul_din1;
        end
        assign we_w[g]    = bus.c_we;
        assign done_w[g]  = bus.done;
        assign busy_w[g]  = bus.busy;
        assign mce_w[g]   = bus.mul_ce;
        assign caddr_w[g] = 12'(bus.c_addr);
        assign cd_w[g]    = bus.c_d;
        assign quiet_w[g] = !(bus.busy || bus.done || bus.a_ce || bus.b_ce || bus.mul_ce || bus.c_we)
                            && bus.a_addr == '0 && bus.b_addr == '0 && bus.c_addr == '0 && bus.c_d == '0;
    end

    task automatic check(input int g, input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dim%0d: got %0d, want %0d", name, 1 << g, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (mce_w[g]) mce_cnt[g]++;
            if (we_w[g]) begin
                exp_t e;
                if (exp_q[g].size() == 0) check(g, "unexpected_c_we_count", exp_q[g].size() + 1, 0);
                else begin
                    e = exp_q[g].pop_front();
                    check(g, "c_addr", longint'(caddr_w[g]), e.addr);
                    check(g, "c_d", longint'(cd_w[g]), e.data);
                    check(g, "c_we_cycle", longint'(($time - t1[g]) / 10) + 1, e.cyc);
                end
            end
        end
    end

    task automatic fill_random(input int g);
        for (int x = 0; x < 64; x++) begin
            a_mem[g][x] = 14'($urandom_range(0, 16383));
            b_mem[g][x] = 14'($urandom_range(0, 16383));
        end
    endtask

    // pulse: also raise start once in RUN and once in DONE; rst_at: pull reset at that cycle instead of finishing
    task automatic run(input int g, input bit pulse, input int rst_at);
        int  d = 1 << g;
        int  n3 = d * d * d;
        int  m0;
        bit  seen = 1'b0;
        for (int i = 0; i < d; i++)
            for (int j = 0; j < d; j++) begin
                exp_t   e;
                longint s = 0;
                for (int k = 0; k < d; k++) s += longint'(a_mem[g][i * d + k]) * longint'(b_mem[g][k * d + j]);
                e.cyc  = d + 2 + (i * d + j) * d;
                e.addr = i * d + j;
                e.data = s;
                exp_q[g].push_back(e);
            end
        @(negedge clk);
        check(g, "idle_before_start", busy_w[g], 0);
        start_r[g] = 1'b1;
        @(posedge clk);
        t1[g] = $time;
        m0 = mce_cnt[g];
        #1 start_r[g] = 1'b0;
        for (int n = 1; n <= n3 + 10 && !seen; n++) begin
            @(negedge clk);
            if (n == rst_at) begin
                #2 rn[g] = 1'b0;
                #1 check(g, "reset_async_quiet", quiet_w[g], 1);
                exp_q[g].delete();
                repeat (3) begin
                    @(negedge clk);
                    check(g, "reset_hold_quiet", quiet_w[g], 1);
                end
                rn[g] = 1'b1;
                return;
            end
            start_r[g] = pulse && n == 5;
            if (done_w[g]) begin
                seen = 1'b1;
                check(g, "done_cycle", n, n3 + 3);
                check(g, "busy_with_done", busy_w[g], 1);
                if (pulse) begin
                    start_r[g] = 1'b1;
                    @(posedge clk);
                    #1 start_r[g] = 1'b0;
                end
            end
        end
        if (!seen) check(g, "done_timeout", 0, 1);
        check(g, "writes_outstanding", exp_q[g].size(), 0);
        check(g, "mul_ce_cycles", mce_cnt[g] - m0, n3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) check(g, "reset_outputs_zero", quiet_w[g], 1);
        for (int g = 0; g < 4; g++) rn[g] = 1'b1;
        for (int x = 0; x < 4; x++) begin
            a_mem[1][x] = (x == 0 || x == 3) ? 14'd1 : 14'd0;
            b_mem[1][x] = 14'(x + 1);
        end
        run(1, 1'b0, 0);
        for (int x = 0; x < 64; x++) begin
            a_mem[3][x] = 14'd16383;
            b_mem[3][x] = 14'd16383;
        end
        run(3, 1'b1, 0);
        run(3, 1'b0, 0);
        fill_random(3);
        run(3, 1'b0, 20);
        run(3, 1'b0, 0);
        a_mem[0][0] = 14'd5;
        b_mem[0][0] = 14'd7;
        run(0, 1'b0, 0);
        repeat (3) begin
            fill_random(2);
            run(2, 1'b0, 0);
        end
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
